// File: rtl/vx_mem_bus_responder_pkg.sv
// Shared constants and helpers for the memory-bus responder.
package vx_mem_bus_responder_pkg;

    localparam int unsigned VX_BYTE_W = 8;

    // Width of a counter that must hold values 0..n inclusive.
    function automatic int unsigned vx_cnt_width(input int unsigned n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/vx_mem_bus_responder_fifo.sv
// First-word-fall-through response queue; head entry is visible whenever not empty.
module vx_mem_bus_responder_fifo
    import vx_mem_bus_responder_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic             i_clk,
    input  logic             i_reset_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_data,
    output logic             o_empty,
    output logic             o_full
);
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = vx_cnt_width(DEPTH);

    logic [WIDTH-1:0] r_store [DEPTH];
    logic [PTR_W-1:0] r_wptr;
    logic [PTR_W-1:0] r_rptr;
    logic [CNT_W-1:0] r_count;

    // Pointer advance with explicit wrap so non-power-of-2 depths also work.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // Entry storage; contents are don't-care until written, so no reset.
    always_ff @(posedge i_clk) begin
        if (i_push) begin
            r_store[r_wptr] <= i_data;
        end
    end

    // Pointers and occupancy; reset empties the queue and drops pending entries.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (i_push) r_wptr <= ptr_inc(r_wptr);
            if (i_pop)  r_rptr <= ptr_inc(r_rptr);
            if (i_push && !i_pop)      r_count <= r_count + CNT_W'(1);
            else if (!i_push && i_pop) r_count <= r_count - CNT_W'(1);
        end
    end

    assign o_data  = r_store[r_rptr];
    assign o_empty = (r_count == '0);
    assign o_full  = (r_count == CNT_W'(DEPTH));

    overflow_chk: assert property (@(posedge i_clk) disable iff (!i_reset_n) i_push |-> !o_full);
    underflow_chk: assert property (@(posedge i_clk) disable iff (!i_reset_n) i_pop |-> !o_empty);

endmodule

// File: rtl/vx_mem_bus_responder.sv
// Responder end of the dcache memory bus: word-addressed SRAM with fixed-latency tagged replies.
module vx_mem_bus_responder
    import vx_mem_bus_responder_pkg::*;
#(
    parameter int unsigned DATA_SIZE      = 4,
    parameter int unsigned ADDR_WIDTH     = 30,
    parameter int unsigned TAG_WIDTH      = 8,
    parameter int unsigned FLAGS_WIDTH    = 1,
    parameter int unsigned MEM_WORDS      = 1024,
    parameter int unsigned LATENCY        = 2,
    parameter int unsigned RSP_QUEUE_SIZE = 4,
    parameter bit          WRITE_ACK      = 1'b0
) (
    input  logic                            i_clk,
    input  logic                            i_reset_n,
    input  logic                            i_req_valid,
    input  logic                            i_req_rw,
    input  logic [ADDR_WIDTH-1:0]           i_req_addr,
    input  logic [DATA_SIZE-1:0]            i_req_byteen,
    input  logic [FLAGS_WIDTH-1:0]          i_req_flags,
    input  logic [DATA_SIZE*VX_BYTE_W-1:0]  i_req_data,
    input  logic [TAG_WIDTH-1:0]            i_req_tag,
    output logic                            o_req_ready,
    output logic                            o_rsp_valid,
    output logic [DATA_SIZE*VX_BYTE_W-1:0]  o_rsp_data,
    output logic [TAG_WIDTH-1:0]            o_rsp_tag,
    input  logic                            i_rsp_ready
);
    localparam int unsigned DATA_W = DATA_SIZE * VX_BYTE_W;
    localparam int unsigned IDX_W  = $clog2(MEM_WORDS);
    localparam int unsigned CNT_W  = vx_cnt_width(RSP_QUEUE_SIZE);

    typedef struct packed {
        logic [TAG_WIDTH-1:0] tag;
        logic [DATA_W-1:0]    data;
    } rsp_entry_t;

    if (LATENCY < 1) begin : g_bad_latency
        $error("LATENCY must be at least 1");
    end
    if (RSP_QUEUE_SIZE < LATENCY) begin : g_bad_queue
        $error("RSP_QUEUE_SIZE must be >= LATENCY to sustain one response per cycle");
    end
    if ((MEM_WORDS & (MEM_WORDS - 1)) != 0) begin : g_bad_words
        $error("MEM_WORDS must be a power of two");
    end

    logic [DATA_W-1:0]    r_mem     [MEM_WORDS];
    logic [LATENCY-1:0]   r_dl_valid;
    logic [TAG_WIDTH-1:0] r_dl_tag  [LATENCY];
    logic [DATA_W-1:0]    r_dl_data [LATENCY];
    logic [CNT_W-1:0]     r_credits;
    logic [CNT_W-1:0]     w_credits_next;

    logic [IDX_W-1:0] w_idx;
    logic             w_accept;
    logic             w_produce;
    logic             w_rsp_fire;
    logic             w_fifo_push;
    logic             w_fifo_pop;
    logic             w_fifo_empty;
    logic             w_fifo_full;
    rsp_entry_t       w_dl_entry;
    rsp_entry_t       w_fifo_head;
    rsp_entry_t       w_head;
    logic             w_unused;

    // Upper address bits alias onto the same words.
    assign w_idx       = i_req_addr[IDX_W-1:0];
    // Ready is a pure function of the credit register, never of i_rsp_ready.
    assign o_req_ready = (r_credits < CNT_W'(RSP_QUEUE_SIZE));
    assign w_accept    = i_req_valid && o_req_ready;
    assign w_produce   = w_accept && (!i_req_rw || WRITE_ACK);
    assign w_rsp_fire  = o_rsp_valid && i_rsp_ready;
    assign w_unused    = ^{i_req_flags, i_req_addr, w_fifo_full};

    // SRAM byte-enable write plus registered read into delay-line stage 0; storage is never reset.
    always_ff @(posedge i_clk) begin
        if (w_accept && i_req_rw) begin
            for (int b = 0; b < int'(DATA_SIZE); b++) begin
                if (i_req_byteen[b]) begin
                    r_mem[w_idx][b*VX_BYTE_W +: VX_BYTE_W] <= i_req_data[b*VX_BYTE_W +: VX_BYTE_W];
                end
            end
        end
        r_dl_data[0] <= i_req_rw ? '0 : r_mem[w_idx];
        r_dl_tag[0]  <= i_req_tag;
        for (int k = 1; k < int'(LATENCY); k++) begin
            r_dl_data[k] <= r_dl_data[k-1];
            r_dl_tag[k]  <= r_dl_tag[k-1];
        end
    end

    // Unstalled valid pipe; only response-producing requests enter it.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_dl_valid <= '0;
        end else begin
            r_dl_valid[0] <= w_produce;
            for (int k = 1; k < int'(LATENCY); k++) begin
                r_dl_valid[k] <= r_dl_valid[k-1];
            end
        end
    end

    // Outstanding-response count: up on producing accept, down on response fire.
    always_comb begin
        w_credits_next = r_credits;
        if (w_produce && !w_rsp_fire) begin
            w_credits_next = r_credits + CNT_W'(1);
        end else if (!w_produce && w_rsp_fire) begin
            w_credits_next = r_credits - CNT_W'(1);
        end
    end

    // Credit register.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_credits <= '0;
        end else begin
            r_credits <= w_credits_next;
        end
    end

    // Delay-line output bypasses the queue when it is empty and the consumer is ready.
    assign w_dl_entry  = {r_dl_tag[LATENCY-1], r_dl_data[LATENCY-1]};
    assign w_fifo_push = r_dl_valid[LATENCY-1] && !(w_fifo_empty && i_rsp_ready);
    assign w_fifo_pop  = !w_fifo_empty && i_rsp_ready;

    vx_mem_bus_responder_fifo #(
        .WIDTH ($bits(rsp_entry_t)),
        .DEPTH (RSP_QUEUE_SIZE)
    ) u_rsp_queue (
        .i_clk     (i_clk),
        .i_reset_n (i_reset_n),
        .i_push    (w_fifo_push),
        .i_data    (w_dl_entry),
        .i_pop     (w_fifo_pop),
        .o_data    (w_fifo_head),
        .o_empty   (w_fifo_empty),
        .o_full    (w_fifo_full)
    );

    assign w_head      = w_fifo_empty ? w_dl_entry : w_fifo_head;
    assign o_rsp_valid = !w_fifo_empty || r_dl_valid[LATENCY-1];
    assign o_rsp_data  = o_rsp_valid ? w_head.data : '0;
    assign o_rsp_tag   = o_rsp_valid ? w_head.tag : '0;

    fire_needs_credit: assert property (@(posedge i_clk) disable iff (!i_reset_n)
        w_rsp_fire |-> (r_credits != '0));
    credit_bound: assert property (@(posedge i_clk) disable iff (!i_reset_n)
        r_credits <= CNT_W'(RSP_QUEUE_SIZE));
    req_known: assert property (@(posedge i_clk) disable iff (!i_reset_n)
        i_req_valid |-> !$isunknown({i_req_rw, i_req_addr, i_req_byteen, i_req_data, i_req_tag}));

endmodule

// File: tb/tb_vx_mem_bus_responder.sv
// Self-checking bench: scoreboard model of memory contents and expected response stream.
module tb_vx_mem_bus_responder;
    localparam int unsigned LAT  = 2;
    localparam int unsigned QSZ  = 4;
    localparam int unsigned MEMW = 1024;
    localparam int unsigned AW   = 30;
    localparam int unsigned WIN  = 32;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          req_valid;
    logic          req_valid1;
    logic          req_rw;
    logic [AW-1:0] req_addr;
    logic [3:0]    req_byteen;
    logic [0:0]    req_flags;
    logic [31:0]   req_data;
    logic [7:0]    req_tag;
    logic          req_ready;
    logic          req_ready1;
    logic          rsp_valid;
    logic          rsp_valid1;
    logic [31:0]   rsp_data;
    logic [31:0]   rsp_data1;
    logic [7:0]    rsp_tag;
    logic [7:0]    rsp_tag1;
    logic          rsp_ready;
    logic          rsp_ready1;

    always #5 clk = ~clk;

    vx_mem_bus_responder #(
        .DATA_SIZE (4), .ADDR_WIDTH (AW), .TAG_WIDTH (8), .FLAGS_WIDTH (1),
        .MEM_WORDS (MEMW), .LATENCY (LAT), .RSP_QUEUE_SIZE (QSZ), .WRITE_ACK (1'b0)
    ) dut (
        .i_clk (clk), .i_reset_n (reset_n),
        .i_req_valid (req_valid), .i_req_rw (req_rw), .i_req_addr (req_addr),
        .i_req_byteen (req_byteen), .i_req_flags (req_flags), .i_req_data (req_data),
        .i_req_tag (req_tag), .o_req_ready (req_ready),
        .o_rsp_valid (rsp_valid), .o_rsp_data (rsp_data), .o_rsp_tag (rsp_tag),
        .i_rsp_ready (rsp_ready)
    );

    vx_mem_bus_responder #(
        .DATA_SIZE (4), .ADDR_WIDTH (AW), .TAG_WIDTH (8), .FLAGS_WIDTH (1),
        .MEM_WORDS (MEMW), .LATENCY (LAT), .RSP_QUEUE_SIZE (QSZ), .WRITE_ACK (1'b1)
    ) dut_ack (
        .i_clk (clk), .i_reset_n (reset_n),
        .i_req_valid (req_valid1), .i_req_rw (req_rw), .i_req_addr (req_addr),
        .i_req_byteen (req_byteen), .i_req_flags (req_flags), .i_req_data (req_data),
        .i_req_tag (req_tag), .o_req_ready (req_ready1),
        .o_rsp_valid (rsp_valid1), .o_rsp_data (rsp_data1), .o_rsp_tag (rsp_tag1),
        .i_rsp_ready (rsp_ready1)
    );

    typedef struct {
        logic [7:0]  tag;
        logic [31:0] data;
        int unsigned due;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] mmem [MEMW];
    int unsigned cyc = 0;
    int          checks = 0;
    int          errors = 0;
    int unsigned fire_cnt = 0;
    int unsigned last_fire_cyc = 0;
    int unsigned dut_acc_cnt = 0;
    logic [31:0] last_fire_data = '0;
    logic [7:0]  last_fire_tag = '0;

    task automatic expect_eq(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", name, got, exp);
        end
    endtask

    // One clock of dut: check outputs against the model, then advance the model over the edge.
    task automatic cycle(output bit acc);
        bit exp_valid;
        bit exp_ready;
        bit fire;
        exp_t e;
        logic [9:0] idx;
        @(negedge clk);
        exp_ready = (exp_q.size() < QSZ);
        exp_valid = (exp_q.size() > 0) && (exp_q[0].due <= cyc);
        expect_eq("req_ready", 32'(req_ready), 32'(exp_ready));
        expect_eq("rsp_valid", 32'(rsp_valid), 32'(exp_valid));
        if (exp_valid) begin
            expect_eq("rsp_data", rsp_data, exp_q[0].data);
            expect_eq("rsp_tag", 32'(rsp_tag), 32'(exp_q[0].tag));
        end
        if (rsp_valid && rsp_ready) begin
            fire_cnt++;
            last_fire_cyc  = cyc;
            last_fire_data = rsp_data;
            last_fire_tag  = rsp_tag;
        end
        if (req_valid && req_ready) dut_acc_cnt++;
        fire = exp_valid && rsp_ready;
        acc  = req_valid && exp_ready;
        if (fire) void'(exp_q.pop_front());
        if (acc) begin
            idx = req_addr[9:0];
            if (req_rw) begin
                for (int b = 0; b < 4; b++) begin
                    if (req_byteen[b]) mmem[idx][b*8 +: 8] = req_data[b*8 +: 8];
                end
            end else begin
                e.tag  = req_tag;
                e.data = mmem[idx];
                e.due  = cyc + LAT;
                exp_q.push_back(e);
            end
        end
        @(posedge clk);
        cyc++;
        #1;
    endtask

    task automatic issue(input bit rw, input logic [AW-1:0] addr, input logic [31:0] data,
                         input logic [3:0] be, input logic [7:0] tag);
        bit acc;
        int n;
        req_valid  = 1'b1;
        req_rw     = rw;
        req_addr   = addr;
        req_data   = data;
        req_byteen = be;
        req_tag    = tag;
        acc = 1'b0;
        n   = 0;
        while (!acc && n < 50) begin
            cycle(acc);
            n++;
        end
        if (!acc) expect_eq("accept_timeout", 32'(acc), 32'd1);
    endtask

    task automatic idle(input int n);
        bit acc;
        req_valid = 1'b0;
        for (int i = 0; i < n; i++) cycle(acc);
    endtask

    task automatic drain();
        bit acc;
        int n;
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        n = 0;
        while (exp_q.size() > 0 && n < 60) begin
            cycle(acc);
            n++;
        end
        cycle(acc);
    endtask

    // Directed step on the write-acking instance.
    task automatic ack_step(input string name, input bit ev, input logic [31:0] ed,
                            input logic [7:0] et);
        @(negedge clk);
        expect_eq({name, "_valid"}, 32'(rsp_valid1), 32'(ev));
        if (ev) begin
            expect_eq({name, "_data"}, rsp_data1, ed);
            expect_eq({name, "_tag"}, 32'(rsp_tag1), 32'(et));
        end
        @(posedge clk);
        #1;
    endtask

    task automatic ack_issue(input string name, input bit rw, input logic [31:0] data,
                             input logic [3:0] be, input logic [7:0] tag);
        req_valid1 = 1'b1;
        req_rw     = rw;
        req_addr   = AW'(7);
        req_data   = data;
        req_byteen = be;
        req_tag    = tag;
        @(negedge clk);
        expect_eq({name, "_ready"}, 32'(req_ready1), 32'd1);
        @(posedge clk);
        #1;
        req_valid1 = 1'b0;
    endtask

    initial begin
        bit          acc;
        int unsigned base;
        int unsigned start;
        int unsigned acc_cyc;

        reset_n    = 1'b0;
        req_valid  = 1'b0;
        req_valid1 = 1'b0;
        req_rw     = 1'b0;
        req_addr   = '0;
        req_byteen = '0;
        req_flags  = '0;
        req_data   = '0;
        req_tag    = '0;
        rsp_ready  = 1'b1;
        rsp_ready1 = 1'b1;
        #1;
        expect_eq("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        expect_eq("reset_rsp_data", rsp_data, 32'd0);
        expect_eq("reset_rsp_tag", 32'(rsp_tag), 32'd0);
        expect_eq("reset_rsp_valid_ack", 32'(rsp_valid1), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        // Fill the working window so every later read has a known value.
        for (int i = 0; i < int'(WIN); i++) issue(1'b1, AW'(i), $urandom, 4'hF, 8'h00);
        idle(2);

        // Full write then read with exact latency.
        issue(1'b1, AW'(16), 32'hDEADBEEF, 4'hF, 8'h00);
        issue(1'b0, AW'(16), 32'h0, 4'h0, 8'd5);
        acc_cyc = cyc - 1;
        drain();
        expect_eq("raw_data", last_fire_data, 32'hDEADBEEF);
        expect_eq("raw_tag", 32'(last_fire_tag), 32'd5);
        expect_eq("raw_latency", last_fire_cyc - acc_cyc, LAT);

        // Partial byte-enable write.
        issue(1'b1, AW'(16), 32'h11223344, 4'b0101, 8'h00);
        issue(1'b0, AW'(16), 32'h0, 4'h0, 8'd6);
        drain();
        expect_eq("partial_data", last_fire_data, 32'hDE22BE44);

        // Upper address bits alias.
        issue(1'b1, AW'(MEMW + 3), 32'hA5A5A5A5, 4'hF, 8'h00);
        issue(1'b0, AW'(3), 32'h0, 4'h0, 8'd7);
        drain();
        expect_eq("alias_data", last_fire_data, 32'hA5A5A5A5);

        // Backpressure: only QSZ reads accepted while responses are held.
        rsp_ready = 1'b0;
        base = dut_acc_cnt;
        start = fire_cnt;
        for (int i = 0; i < 4; i++) issue(1'b0, AW'(i), 32'h0, 4'h0, 8'(32 + i));
        req_valid = 1'b1;
        req_addr  = AW'(4);
        req_tag   = 8'h24;
        repeat (8) cycle(acc);
        expect_eq("bp_accepted", dut_acc_cnt - base, 32'd4);
        expect_eq("bp_ready_low", 32'(req_ready), 32'd0);
        expect_eq("bp_head_tag", 32'(rsp_tag), 32'h20);
        rsp_ready = 1'b1;
        issue(1'b0, AW'(4), 32'h0, 4'h0, 8'h24);
        issue(1'b0, AW'(5), 32'h0, 4'h0, 8'h25);
        drain();
        expect_eq("bp_rsp_count", fire_cnt - start, 32'd6);
        expect_eq("bp_last_tag", 32'(last_fire_tag), 32'h25);

        // Streaming reads, one per cycle.
        base = fire_cnt;
        issue(1'b0, AW'($urandom_range(0, WIN - 1)), 32'h0, 4'h0, 8'd0);
        start = cyc - 1;
        for (int i = 1; i < 100; i++) begin
            issue(1'b0, AW'($urandom_range(0, WIN - 1)), 32'h0, 4'h0, 8'(i));
        end
        drain();
        expect_eq("stream_count", fire_cnt - base, 32'd100);
        expect_eq("stream_span", last_fire_cyc - start, 99 + LAT);

        // Random mixed traffic with random backpressure.
        for (int i = 0; i < 300; i++) begin
            req_valid  = 1'($urandom_range(0, 1));
            req_rw     = ($urandom_range(0, 3) == 0);
            req_addr   = AW'($urandom_range(0, 3) * MEMW + $urandom_range(0, WIN - 1));
            req_data   = $urandom;
            req_byteen = 4'($urandom_range(0, 15));
            req_tag    = 8'($urandom_range(0, 255));
            rsp_ready  = ($urandom_range(0, 3) != 0);
            cycle(acc);
        end
        drain();

        // Reset with three reads in flight.
        rsp_ready = 1'b0;
        for (int i = 0; i < 3; i++) issue(1'b0, AW'(i), 32'h0, 4'h0, 8'(64 + i));
        req_valid = 1'b0;
        expect_eq("pre_reset_valid", 32'(rsp_valid), 32'd1);
        #1;
        reset_n = 1'b0;
        #1;
        expect_eq("midreset_valid", 32'(rsp_valid), 32'd0);
        expect_eq("midreset_data", rsp_data, 32'd0);
        expect_eq("midreset_tag", 32'(rsp_tag), 32'd0);
        exp_q.delete();
        @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        cyc++;
        #1;
        rsp_ready = 1'b1;
        idle(8);
        issue(1'b0, AW'(1), 32'h0, 4'h0, 8'd99);
        drain();

        // Write-acking instance: writes answer with zero data.
        ack_issue("ack_wr", 1'b1, 32'hCAFEF00D, 4'hF, 8'd9);
        ack_step("ack_wr_t1", 1'b0, 32'h0, 8'd0);
        ack_step("ack_wr_t2", 1'b1, 32'h0, 8'd9);
        ack_issue("ack_rd", 1'b0, 32'h0, 4'h0, 8'd10);
        ack_step("ack_rd_t1", 1'b0, 32'h0, 8'd0);
        ack_step("ack_rd_t2", 1'b1, 32'hCAFEF00D, 8'd10);
        ack_issue("ack_nobe", 1'b1, 32'hFFFFFFFF, 4'h0, 8'd11);
        ack_step("ack_nobe_t1", 1'b0, 32'h0, 8'd0);
        ack_step("ack_nobe_t2", 1'b1, 32'h0, 8'd11);
        ack_issue("ack_rd2", 1'b0, 32'h0, 4'h0, 8'd12);
        ack_step("ack_rd2_t1", 1'b0, 32'h0, 8'd0);
        ack_step("ack_rd2_t2", 1'b1, 32'hCAFEF00D, 8'd12);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
